apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB3 requester that sits directly upstream of the peripheral slaves (FIFO, GPIO, UART, ...).
- Converts a simple CPU-side request (transfer/addr/write/wdata) into legal APB SETUP/ACCESS phases.
- Decodes the address onto one of NUM_SLAVES PSEL lines and returns the selected slave's PRDATA/PREADY to the requester.

Parameters:
- NUM_SLAVES, 4, number of PSEL outputs / PRDATA-PREADY inputs (1..16).
- BASE_ADDR, 32'h1000_0000, start of peripheral window; slave i occupies BASE_ADDR + i*0x100 .. +0xFF.
- TIMEOUT, 16, ACCESS-phase cycles allowed before abort (used only with APB_MASTER_TIMEOUT_EN).

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous, active-low reset (0 = reset).
- transfer  in  1  request valid; sampled only when the block can accept.
- addr  in  32  request byte address.
- write  in  1  1 = write, 0 = read.
- wdata  in  32  write data.
- rdata  out  32  read data, valid in the ready cycle.
- ready  out  1  one-cycle completion pulse.
- err  out  1  completion is an error (decode miss or timeout); valid with ready.
- busy  out  1  a transfer is in SETUP or ACCESS.
- PADDR  out  32  APB address (full request address, unmodified).
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB access phase.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA  in  NUM_SLAVES x 32  per-slave read data (unpacked array).
- PREADY  in  NUM_SLAVES  per-slave ready.

Behaviour:
- Reset (PRESET=0, async):
  - state=IDLE.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - rdata=0, ready=0, err=0, busy=0.
- FSM states IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - If transfer=1 at posedge: latch addr/write/wdata into PADDR/PWRITE/PWDATA and decode.
  - Decode hit: go to SETUP with PSEL[idx]=1, PENABLE=0.
  - Decode miss: stay IDLE, no PSEL. Next cycle: ready=1, err=1, rdata=0.
- Decode rule:
  - Hit iff addr[31:8] - BASE_ADDR[31:8] < NUM_SLAVES.
  - idx = that difference; addr[7:0] goes to the slave via PADDR.
- SETUP: unconditionally go to ACCESS (PENABLE=1) after exactly 1 cycle; PSEL, PADDR, PWRITE and PWDATA are held.
- ACCESS:
  - Wait while PREADY[idx]=0; all APB outputs stay stable.
  - On a posedge with PREADY[idx]=1:
    - Latch rdata = PRDATA[idx] on reads; rdata is unchanged on writes.
    - Next cycle: ready=1, err=0, PENABLE=0.
    - If transfer=1 on the same edge: latch the new request and go directly to SETUP (back-to-back, no idle cycle).
    - Otherwise clear PSEL and go to IDLE.
- PREADY from unselected slaves is ignored.
- Latency: minimum 2 APB cycles (SETUP + ACCESS); ready appears on the cycle after the completing edge.
- transfer is ignored while busy=1 except on the completing edge. Requesters must hold transfer until accepted. Accepted = edge where state is IDLE, or the completing ACCESS edge.
- busy=1 in SETUP and ACCESS.
- Reset asserted mid-transfer: immediate return to the reset values; no ready pulse.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle with PREADY[idx]=0.
  - When the count reaches TIMEOUT, abort: PSEL=0, PENABLE=0, go to IDLE, then ready=1, err=1, rdata=32'hDEAD_BEEF.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package apb_pkg:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t.
  - localparam APB_SLOT_BITS=8.
  - localparam logic [31:0] APB_TIMEOUT_DATA=32'hDEAD_BEEF.
- One natural sub-module: apb_addr_decoder (combinational addr -> hit, idx, one-hot sel).

Test Plan:
- Reset, then write 0x1000_0004 <= 0xAA to slave 0 (PREADY tied 1) -> PSEL=0001; SETUP 1 cycle, ACCESS 1 cycle, PADDR[3:0]=4; ready=1, err=0 two cycles after acceptance.
- Read 0x1000_0108 from slave 1 with PREADY delayed 3 cycles, PRDATA=0xBB -> PENABLE high 4 cycles; PADDR/PSEL stable throughout; rdata=0xBB, ready pulses once.
- Back-to-back: transfer held high for write 0x1000_0004 then read 0x1000_0000 -> second SETUP immediately follows first ACCESS; PSEL never drops; two ready pulses.
- Unmapped read 0x2000_0000 -> no PSEL/PENABLE activity; ready=1, err=1, rdata=0 on next cycle.
- PRESET driven low during ACCESS -> PSEL=0, PENABLE=0, busy=0 immediately; no ready pulse; the next request completes normally.
- (APB_MASTER_TIMEOUT_EN) slave 2 PREADY stuck 0 -> abort after 16 ACCESS cycles; ready=1, err=1, rdata=0xDEAD_BEEF.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state type and constants for the APB requester
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int          APB_SLOT_BITS    = 8;
    localparam logic [31:0] APB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - APB3 bus bundle between the requester and its peripheral slaves
interface apb_master_if #(
    parameter int NUM_SLAVES = 4
);
    logic [31:0]           PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PENABLE;
    logic [NUM_SLAVES-1:0] PSEL;
    logic [31:0]           PRDATA [NUM_SLAVES];
    logic [NUM_SLAVES-1:0] PREADY;

    modport master (
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - maps the 256-byte slot of an address onto a slave index and one-hot select
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          IDX_W      = 2
) (
    input  logic [31-APB_SLOT_BITS:0] slot_addr,
    output logic                      hit,
    output logic [IDX_W-1:0]          idx,
    output logic [NUM_SLAVES-1:0]     sel
);
    localparam int SLOT_W = 32 - APB_SLOT_BITS;

    logic [SLOT_W-1:0] diff;

    // Unsigned wrap makes addresses below the window land far above NUM_SLAVES.
    always_comb begin
        diff = slot_addr - BASE_ADDR[31:APB_SLOT_BITS];
        hit  = diff < SLOT_W'(NUM_SLAVES);
        idx  = diff[IDX_W-1:0];
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = hit && (diff == SLOT_W'(i));
        end
    end
endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB3 requester with slot decode; APB_MASTER_TIMEOUT_EN adds an ACCESS-phase abort
module apb_master
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          TIMEOUT    = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    input  logic         transfer,
    input  logic [31:0]  addr,
    input  logic         write,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic         ready,
    output logic         err,
    output logic         busy,
    apb_master_if.master apb
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT < 1) begin : g_param_check
        $error("apb_master: parameter out of range");
    end

    apb_state_t            state;
    logic [NUM_SLAVES-1:0] psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [31:0]           paddr_q;
    logic [31:0]           pwdata_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  pend_miss;

    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  sel_ready;
    logic                  accept_new;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;
`endif

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_dec (
        .slot_addr (addr[31:APB_SLOT_BITS]),
        .hit       (dec_hit),
        .idx       (dec_idx),
        .sel       (dec_sel)
    );

    assign sel_ready  = apb.PREADY[idx_q];
    assign accept_new = transfer && ((state == IDLE) || ((state == ACCESS) && sel_ready));

    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PENABLE = penable_q;
    assign apb.PSEL    = psel_q;
    assign busy        = (state != IDLE);

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else if (accept_new) begin
            paddr_q  <= addr;
            pwdata_q <= wdata;
            pwrite_q <= write;
        end
    end

    // A miss accepted on a completing edge cannot share that edge's ready pulse,
    // so it is parked in pend_miss and reported from IDLE one cycle later.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state     <= IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            idx_q     <= '0;
            pend_miss <= 1'b0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_miss) begin
                        ready     <= 1'b1;
                        err       <= 1'b1;
                        rdata     <= '0;
                        pend_miss <= 1'b0;
                    end
                    if (transfer) begin
                        if (dec_hit) begin
                            psel_q <= dec_sel;
                            idx_q  <= dec_idx;
                            state  <= SETUP;
                        end else if (pend_miss) begin
                            pend_miss <= 1'b1;
                        end else begin
                            ready <= 1'b1;
                            err   <= 1'b1;
                            rdata <= '0;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end
                ACCESS: begin
                    if (sel_ready) begin
                        if (!pwrite_q) rdata <= apb.PRDATA[idx_q];
                        ready     <= 1'b1;
                        penable_q <= 1'b0;
                        if (transfer && dec_hit) begin
                            psel_q <= dec_sel;
                            idx_q  <= dec_idx;
                            state  <= SETUP;
                        end else begin
                            psel_q    <= '0;
                            pend_miss <= transfer;
                            state     <= IDLE;
                        end
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        ready     <= 1'b1;
                        err       <= 1'b1;
                        rdata     <= APB_TIMEOUT_DATA;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized and directed checks of apb_master against a transaction-level model
module tb_apb_master;
    localparam int          NS   = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] WEND = BASE + 32'(NS * 256);

    logic        PCLK     = 1'b0;
    logic        PRESET   = 1'b0;
    logic        transfer = 1'b0;
    logic [31:0] addr     = '0;
    logic        write    = 1'b0;
    logic [31:0] wdata    = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    apb_master_if #(.NUM_SLAVES(NS)) apb ();

    apb_master #(
        .NUM_SLAVES (NS),
        .BASE_ADDR  (BASE),
        .TIMEOUT    (16)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .addr     (addr),
        .write    (write),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .busy     (busy),
        .apb      (apb)
    );

    always #5 PCLK = ~PCLK;

    logic          rdy_go  = 1'b1;
    logic [NS-1:0] noise   = '0;
    logic          ovr_en  = 1'b0;
    logic [31:0]   ovr_val = '0;
    logic [31:0]   smem [NS][64];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int s, input int w);
        return 32'hA000_0000 + 32'(s * 256 + w);
    endfunction

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            apb.PREADY[i] = apb.PSEL[i] ? rdy_go : noise[i];
            apb.PRDATA[i] = ovr_en ? ovr_val : smem[i][apb.PADDR[7:2]];
        end
    end

    always @(posedge PCLK) begin
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < 64; j++) begin
                if (!PRESET)
                    smem[i][j] <= init_word(i, j);
                else if (apb.PSEL[i] && apb.PENABLE && apb.PREADY[i] && apb.PWRITE && apb.PADDR[7:2] == 6'(j))
                    smem[i][j] <= apb.PWDATA;
            end
        end
    end

    task automatic run_random(input int n);
        logic [31:0] mmem [NS][64];
        logic [31:0] last_rd = '0;
        logic [32:0] exp_q [$];
        logic [32:0] e;
        logic [69:0] snap = '0;
        logic [31:0] ra = '0;
        logic [31:0] rw = '0;
        bit          rwr = 1'b0;
        bit          have = 1'b0;
        bit          prev_wait = 1'b0;
        int          issued = 0;
        int          gap = 0;
        int          s;
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < 64; j++) mmem[i][j] = init_word(i, j);
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(negedge PCLK);
            if (ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_extra_ready", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_err", err, e[32]);
                    check("rand_rdata", rdata, e[31:0]);
                end
            end
            if (prev_wait)
                check("rand_hold", {apb.PSEL, apb.PADDR, apb.PWDATA, apb.PWRITE, apb.PENABLE} == snap, 1);
            rdy_go = ($urandom_range(2) != 0);
            noise  = NS'($urandom);
            if (!have && issued < n) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    if ($urandom_range(9) < 8) begin
                        ra = BASE + 32'($urandom_range(NS - 1) * 256) + 32'($urandom_range(3) * 4);
                    end else begin
                        case ($urandom_range(3))
                            0:       ra = BASE - 32'd4;
                            1:       ra = WEND;
                            2:       ra = 32'h2000_0000;
                            default: ra = WEND - 32'd4;
                        endcase
                    end
                    rwr  = $urandom_range(1) == 1;
                    rw   = $urandom;
                    have = 1'b1;
                end
            end
            transfer = have;
            if (have) begin
                addr  = ra;
                write = rwr;
                wdata = rw;
            end
            if (have && (!busy || (apb.PENABLE && rdy_go))) begin
                if (ra < BASE || ra >= WEND) begin
                    last_rd = '0;
                    e = {1'b1, 32'h0};
                end else begin
                    s = int'((ra - BASE) >> 8);
                    if (rwr) mmem[s][ra[7:2]] = rw;
                    else     last_rd = mmem[s][ra[7:2]];
                    e = {1'b0, last_rd};
                end
                exp_q.push_back(e);
                have = 1'b0;
                issued++;
                gap = $urandom_range(2);
            end
            prev_wait = apb.PENABLE && !rdy_go;
            snap = {apb.PSEL, apb.PADDR, apb.PWDATA, apb.PWRITE, apb.PENABLE};
            if (issued == n && !have && exp_q.size() == 0) break;
        end
        transfer = 1'b0;
        check("rand_issued", issued, n);
        check("rand_drain", exp_q.size(), 0);
    endtask

    initial begin
        int  cnt;
        int  nrdy;
        bit  stable;
        bit  got;

        repeat (2) @(negedge PCLK);
        check("rst_psel", apb.PSEL, 0);
        check("rst_penable", apb.PENABLE, 0);
        check("rst_pwrite", apb.PWRITE, 0);
        check("rst_paddr", apb.PADDR, 0);
        check("rst_pwdata", apb.PWDATA, 0);
        check("rst_rdata", rdata, 0);
        check("rst_ready", ready, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        @(negedge PCLK);
        PRESET = 1'b1;

        run_random(250);

        // single write, zero wait states
        @(negedge PCLK);
        rdy_go = 1'b1; ovr_en = 1'b0;
        transfer = 1'b1; addr = 32'h1000_0004; write = 1'b1; wdata = 32'hAA;
        @(negedge PCLK);
        transfer = 1'b0;
        check("t1_psel", apb.PSEL, 4'b0001);
        check("t1_setup_pen", apb.PENABLE, 0);
        check("t1_paddr_lo", apb.PADDR[3:0], 4);
        check("t1_pwdata", apb.PWDATA, 32'hAA);
        check("t1_pwrite", apb.PWRITE, 1);
        check("t1_busy", busy, 1);
        @(negedge PCLK);
        check("t1_access_pen", apb.PENABLE, 1);
        check("t1_access_psel", apb.PSEL, 4'b0001);
        check("t1_early_ready", ready, 0);
        @(negedge PCLK);
        check("t1_ready", ready, 1);
        check("t1_err", err, 0);
        check("t1_pen_off", apb.PENABLE, 0);
        check("t1_psel_off", apb.PSEL, 0);
        check("t1_idle", busy, 0);

        // read with three wait states
        @(negedge PCLK);
        transfer = 1'b1; addr = 32'h1000_0108; write = 1'b0;
        rdy_go = 1'b0; ovr_en = 1'b1; ovr_val = 32'hBB;
        @(negedge PCLK);
        transfer = 1'b0;
        check("t2_psel", apb.PSEL, 4'b0010);
        cnt = 0; stable = 1'b1; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            if (ready) begin
                got = 1'b1;
                break;
            end
            if (apb.PENABLE) begin
                cnt++;
                if (apb.PSEL != 4'b0010 || apb.PADDR != 32'h1000_0108) stable = 1'b0;
                if (cnt == 4) rdy_go = 1'b1;
            end
        end
        check("t2_done", got, 1);
        check("t2_pen_cycles", cnt, 4);
        check("t2_stable", stable, 1);
        check("t2_rdata", rdata, 32'hBB);
        check("t2_err", err, 0);
        @(negedge PCLK);
        check("t2_one_pulse", ready, 0);

        // back-to-back write then read
        rdy_go = 1'b1; ovr_val = 32'hCC;
        transfer = 1'b1; addr = 32'h1000_0004; write = 1'b1; wdata = 32'h11;
        @(negedge PCLK);
        check("t3_psel_a", apb.PSEL, 4'b0001);
        addr = 32'h1000_0000; write = 1'b0;
        @(negedge PCLK);
        check("t3_access_a", apb.PENABLE, 1);
        @(negedge PCLK);
        transfer = 1'b0;
        check("t3_ready_a", ready, 1);
        check("t3_err_a", err, 0);
        check("t3_psel_held", apb.PSEL, 4'b0001);
        check("t3_setup_b", apb.PENABLE, 0);
        check("t3_paddr_b", apb.PADDR, 32'h1000_0000);
        check("t3_pwrite_b", apb.PWRITE, 0);
        @(negedge PCLK);
        check("t3_gap", ready, 0);
        check("t3_access_b", apb.PENABLE, 1);
        @(negedge PCLK);
        check("t3_ready_b", ready, 1);
        check("t3_rdata_b", rdata, 32'hCC);
        ovr_en = 1'b0;

        // unmapped read
        @(negedge PCLK);
        transfer = 1'b1; addr = 32'h2000_0000; write = 1'b0;
        @(negedge PCLK);
        transfer = 1'b0;
        check("t4_ready", ready, 1);
        check("t4_err", err, 1);
        check("t4_rdata", rdata, 0);
        check("t4_psel", apb.PSEL, 0);
        check("t4_pen", apb.PENABLE, 0);
        check("t4_busy", busy, 0);
        @(negedge PCLK);
        check("t4_one_pulse", ready, 0);

        // reset during ACCESS, then a normal transfer
        rdy_go = 1'b0;
        transfer = 1'b1; addr = 32'h1000_0204; write = 1'b1; wdata = 32'h55;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        check("t5_in_access", apb.PENABLE, 1);
        #2 PRESET = 1'b0;
        #1;
        check("t5_psel", apb.PSEL, 0);
        check("t5_pen", apb.PENABLE, 0);
        check("t5_busy", busy, 0);
        check("t5_paddr", apb.PADDR, 0);
        @(negedge PCLK);
        PRESET = 1'b1; rdy_go = 1'b1;
        nrdy = 0;
        repeat (3) begin
            @(negedge PCLK);
            if (ready) nrdy++;
        end
        check("t5_no_ready", nrdy, 0);
        ovr_en = 1'b1; ovr_val = 32'h33;
        transfer = 1'b1; addr = 32'h1000_0300; write = 1'b0;
        @(negedge PCLK);
        transfer = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge PCLK);
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        check("t5_after_done", got, 1);
        check("t5_after_rdata", rdata, 32'h33);
        check("t5_after_err", err, 0);
        ovr_en = 1'b0;

`ifdef APB_MASTER_TIMEOUT_EN
        // stuck slave is aborted
        @(negedge PCLK);
        rdy_go = 1'b0;
        transfer = 1'b1; addr = 32'h1000_0200; write = 1'b0;
        @(negedge PCLK);
        transfer = 1'b0;
        cnt = 0; got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            if (ready) begin
                got = 1'b1;
                break;
            end
            if (apb.PENABLE) cnt++;
        end
        check("t6_done", got, 1);
        check("t6_access_cycles", cnt, 16);
        check("t6_err", err, 1);
        check("t6_rdata", rdata, 32'hDEAD_BEEF);
        check("t6_psel", apb.PSEL, 0);
        rdy_go = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
